// File: rtl/jump_charge.sv
// Jump charge meter: hold the button to build distance, release to fire one jump_dist pulse.
// Latency: jump_dist is registered on the release edge; no backpressure, end_of_jump or a timeout ends each jump.
module jump_charge #(
  parameter int TICKS_PER_UNIT = 4,
  parameter int MAX_DIST       = 31,
  parameter int MIN_DIST       = 1,
  parameter int LAND_TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       jump_btn,
  input  logic       end_of_jump,
  output logic [7:0] jump_dist,
  output logic [7:0] charge,
  output logic       charging,
  output logic       ready
);

  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int TW = (LAND_TIMEOUT > 1) ? $clog2(LAND_TIMEOUT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_UNIT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LAND_TIMEOUT - 1);
  localparam logic [7:0]    MAX_C    = 8'(MAX_DIST);
  localparam logic [7:0]    MIN_C    = 8'(MIN_DIST);

  typedef enum logic [1:0] {IDLE, CHARGE, FIRE, WAIT_LAND} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [7:0]    charge_n, dist_n;
  logic          prev_btn;
  logic          press;

  // Edge-only start: a button still held from an earlier jump never re-arms a charge.
  assign press    = jump_btn & ~prev_btn;
  assign charging = (state == CHARGE);
  assign ready    = (state == IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      presc     <= '0;
      tcnt      <= '0;
      charge    <= '0;
      jump_dist <= '0;
      prev_btn  <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      tcnt      <= tcnt_n;
      charge    <= charge_n;
      jump_dist <= dist_n;
      prev_btn  <= jump_btn;
    end
  end

  always_comb begin
    state_n  = state;
    presc_n  = presc;
    tcnt_n   = tcnt;
    charge_n = charge;
    dist_n   = jump_dist;
    case (state)
      IDLE: begin
        if (press) begin
          state_n  = CHARGE;
          presc_n  = '0;
          charge_n = '0;
        end
      end
      CHARGE: begin
        if (jump_btn) begin
          // Prescaler free-runs even once charge has saturated.
          if (presc == PRE_LAST) begin
            presc_n = '0;
            if (charge < MAX_C) charge_n = charge + 8'd1;
          end else begin
            presc_n = presc + 1'b1;
          end
        end else if (charge >= MIN_C) begin
          state_n = FIRE;
          dist_n  = charge;
        end else begin
          state_n  = IDLE;
          charge_n = '0;
        end
      end
      FIRE: begin
        state_n  = WAIT_LAND;
        dist_n   = '0;
        charge_n = '0;
        tcnt_n   = '0;
      end
      WAIT_LAND: begin
        if (end_of_jump || (tcnt == TO_LAST)) state_n = IDLE;
        else tcnt_n = tcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_jump_charge.sv
// Bench for jump_charge: table of hold lengths, hand sequences for landing/timeout/reset,
// then random button/landing/reset traffic checked every cycle against a hold-count model.
module tb_jump_charge;

  localparam int TPU  = 4;
  localparam int MAXD = 31;
  localparam int MIND = 1;
  localparam int LT   = 64;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       jump_btn = 1'b0;
  logic       end_of_jump = 1'b0;
  logic [7:0] jump_dist, charge;
  logic       charging, ready;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  jump_charge #(
    .TICKS_PER_UNIT(TPU), .MAX_DIST(MAXD), .MIN_DIST(MIND), .LAND_TIMEOUT(LT)
  ) dut (
    .clk(clk), .clr(clr), .jump_btn(jump_btn), .end_of_jump(end_of_jump),
    .jump_dist(jump_dist), .charge(charge), .charging(charging), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 charging, 2 fire, 3 landing.
  // Charge is simply the number of held cycles divided by the tick rate, clipped.
  int m_phase = 0, m_hold = 0, m_wait = 0;
  bit m_prev = 1'b0;
  bit m_press;

  function automatic int m_units();
    int u;
    u = m_hold / TPU;
    return (u > MAXD) ? MAXD : u;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_phase = 0; m_hold = 0; m_wait = 0; m_prev = 1'b0;
    end else begin
      m_press = jump_btn && !m_prev;
      m_prev  = jump_btn;
      case (m_phase)
        0: if (m_press) begin m_phase = 1; m_hold = 0; end
        1: begin
          if (jump_btn) m_hold++;
          else if (m_units() >= MIND) m_phase = 2;
          else m_phase = 0;
        end
        2: begin m_phase = 3; m_wait = 0; end
        default: begin
          if (end_of_jump) m_phase = 0;
          else begin
            m_wait++;
            if (m_wait == LT) m_phase = 0;
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_dist", jump_dist, (m_phase == 2) ? m_units() : 0);
      check("model_charge", charge, (m_phase == 1 || m_phase == 2) ? m_units() : 0);
      check("model_charging", charging, m_phase == 1);
      check("model_ready", ready, m_phase == 0);
    end
  end

  typedef struct {
    int hold;
    int exp_dist;
  } vec_t;

  task automatic run_vec(input int hold, input int exp_dist, input bit land);
    @(negedge clk); jump_btn = 1'b1;
    repeat (hold + 1) @(negedge clk);
    jump_btn = 1'b0;
    @(posedge clk); #1;
    check("release_dist", jump_dist, exp_dist);
    if (exp_dist != 0) check("fire_state", {charging, ready}, 2'b00);
    else check("abort_ready", ready, 1'b1);
    @(posedge clk); #1;
    check("dist_one_cycle", jump_dist, 0);
    if (exp_dist != 0 && land) begin
      @(negedge clk); end_of_jump = 1'b1;
      @(negedge clk); end_of_jump = 1'b0;
      check("landed_ready", ready, 1'b1);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int n;
    int cnt;
    vecs[0] = '{72, 18};
    vecs[1] = '{2, 0};
    vecs[2] = '{3, 0};
    vecs[3] = '{4, 1};
    vecs[4] = '{7, 1};
    vecs[5] = '{123, 30};
    vecs[6] = '{127, 31};
    vecs[7] = '{200, 31};

    #2 clr = 1'b0;
    #1;
    check("reset_dist", jump_dist, 0);
    check("reset_charge", charge, 0);
    check("reset_flags", {charging, ready}, 2'b01);
    chk_en = 1'b1;
    @(negedge clk); clr = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i].hold, vecs[i].exp_dist, 1'b1);

    // No landing: forced return after the timeout, then a normal jump.
    run_vec(8, 2, 1'b0);
    n = 0;
    while (n < 100 && ready !== 1'b1) begin
      @(posedge clk); #1; n++;
    end
    check("timeout_cycles", n, LT);
    run_vec(8, 2, 1'b1);

    // Press held through landing must not start a charge.
    run_vec(12, 3, 1'b0);
    @(negedge clk); jump_btn = 1'b1;
    repeat (3) @(negedge clk);
    end_of_jump = 1'b1;
    @(negedge clk); end_of_jump = 1'b0;
    check("held_land_ready", ready, 1'b1);
    check("held_land_nocharge", charging, 1'b0);
    repeat (5) @(negedge clk);
    check("held_still_idle", charging, 1'b0);
    jump_btn = 1'b0;
    @(negedge clk); jump_btn = 1'b1;
    @(negedge clk);
    check("repress_charging", charging, 1'b1);
    jump_btn = 1'b0;
    @(negedge clk);
    check("repress_abort_ready", ready, 1'b1);

    // Reset at charge 10; button held through reset counts as a fresh press.
    @(negedge clk); jump_btn = 1'b1;
    repeat (41) @(negedge clk);
    check("pre_reset_charge", charge, 10);
    #2 clr = 1'b0;
    #1;
    check("clr_charge", charge, 0);
    check("clr_dist", jump_dist, 0);
    check("clr_flags", {charging, ready}, 2'b01);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    check("held_reset_press", charging, 1'b1);
    @(negedge clk); jump_btn = 1'b0;
    @(posedge clk); #1;
    check("post_reset_nopulse", jump_dist, 0);
    check("post_reset_ready", ready, 1'b1);

    // Random traffic, including saturating holds and rare resets.
    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cnt == 0) begin
        jump_btn = ~jump_btn;
        cnt = ($urandom_range(0, 9) == 0) ? 150 : $urandom_range(1, 40);
      end
      cnt--;
      end_of_jump = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 799) != 0);
    end
    @(negedge clk);
    clr = 1'b1; end_of_jump = 1'b0; jump_btn = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/jump_charge.md
JUMP_CHARGE -- requirements
Module: jump_charge

Interface
REQ-001 Parameter TICKS_PER_UNIT, default 4, clk cycles of held button per distance unit.
REQ-002 Parameter MAX_DIST, default 31, saturation value of charge.
REQ-003 Parameter MIN_DIST, default 1, smallest charge that produces a jump.
REQ-004 Parameter LAND_TIMEOUT, default 64, maximum WAIT_LAND cycles before a forced return to IDLE.
REQ-005 clk  input  1  render clock, shared with the game fsm; all state on rising edge.
REQ-006 clr  input  1  reset, asynchronous, active-low.
REQ-007 jump_btn  input  1  debounced jump button level, synchronous to clk.
REQ-008 end_of_jump  input  1  one-cycle pulse from the game fsm when the player lands.
REQ-009 jump_dist  output  8  jump distance to the fsm; nonzero for exactly one cycle per jump, else 0.
REQ-010 charge  output  8  live charge level, for display.
REQ-011 charging  output  1  high while in CHARGE.
REQ-012 ready  output  1  high while in IDLE.

Function
REQ-013 States SHALL be IDLE, CHARGE, FIRE and WAIT_LAND.
REQ-014 A registered copy of jump_btn SHALL give a press edge (btn=1, prev=0); only edges start a charge, so a held button never restarts one.
REQ-015 IDLE with a press edge: go to CHARGE, prescaler<=0, charge<=0.
REQ-016 CHARGE with btn=1: prescaler increments; at TICKS_PER_UNIT-1 it returns to 0 and charge increments, saturating at MAX_DIST (prescaler keeps running).
REQ-017 CHARGE with btn=0 and charge>=MIN_DIST: go to FIRE and load jump_dist<=charge on the same edge.
REQ-018 CHARGE with btn=0 and charge<MIN_DIST: return to IDLE, charge<=0, no jump_dist pulse.
REQ-019 FIRE lasts one cycle; next edge: jump_dist<=0, charge<=0, timeout counter<=0, go to WAIT_LAND.
REQ-020 WAIT_LAND: jump_btn ignored; end_of_jump returns to IDLE; otherwise the counter increments, reaching LAND_TIMEOUT-1 forces IDLE.
REQ-021 end_of_jump in any state other than WAIT_LAND SHALL be ignored.
REQ-022 Press edge coinciding with end_of_jump in WAIT_LAND: go to IDLE, press not captured; the user must release and re-press.
REQ-023 Latency: release sampled at edge k -> jump_dist valid from edge k to edge k+1.
REQ-024 jump_dist SHALL never exceed MAX_DIST; charge and jump_dist are 8-bit unsigned, MAX_DIST<=255.
REQ-025 charging and ready SHALL be decoded from the state register with no extra latency.

Reset
REQ-026 clr=0 SHALL asynchronously force IDLE, and set jump_dist=0, charge=0, prescaler=0, timeout counter=0, prev btn=0, charging=0, ready=1.
REQ-027 Reset mid-CHARGE or mid-FIRE SHALL abort with no jump_dist pulse after release.
REQ-028 Button held through reset release counts as a press edge on the first clocked edge, because prev btn resets to 0.

Verification (defaults)
REQ-029 Press, hold 72 CHARGE cycles, release -> charge=18, jump_dist=18 for exactly one cycle, then WAIT_LAND.
REQ-030 Press held 3 cycles then released -> charge=0, no jump_dist pulse, ready=1 next cycle.
REQ-031 Hold 200 cycles -> charge saturates at 31, jump_dist=31 on release.
REQ-032 In WAIT_LAND, press and hold, then end_of_jump -> IDLE with ready=1 and no charging until release and re-press.
REQ-033 No end_of_jump after a jump -> IDLE after 64 WAIT_LAND cycles, and the next press charges normally.
REQ-034 clr=0 at charge=10 mid-CHARGE -> all outputs 0 immediately (ready=1), and release after clr=1 gives no pulse.
